tb_frame_ctrl: RTL and testbench
================================

Name: tb_frame_ctrl

Overview:
- Single-clock controller for the triple frame buffer in the Auto_ETS capture path. It converts a valid-qualified sample stream into buffer write strobes: waddr, wdata, w_occur, and a one-hot w_buffer_id.
- It also arbitrates the three buffers between writer, "latest complete" and reader. It generates the read-side sweep: raddr, r_occur, one-hot r_buffer_id.
- The writer never stalls and never overwrites the buffer being read. The reader always gets the most recent complete frame.

Parameters:
MAX_TAP, 616, samples per frame; valid addresses 0..MAX_TAP-1
ADDR_W, 10, width of waddr/raddr; MAX_TAP <= 2^ADDR_W
DATA_W, 32, sample width

Ports:
clk  in  1  single clock for both write and read sides
rst_n  in  1  asynchronous active-low reset
arm  in  1  capture enable; low discards the partial frame
s_valid  in  1  sample strobe
s_data  in  DATA_W  sample
waddr  out  ADDR_W  buffer write address
wdata  out  DATA_W  buffer write data
w_buffer_id  out  3  one-hot write buffer
w_occur  out  1  write strobe
rd_start  in  1  pulse: begin reading latest frame
rd_en  in  1  read advance/stall
raddr  out  ADDR_W  buffer read address
r_buffer_id  out  3  one-hot read buffer; 000 when idle
r_occur  out  1  read strobe
frame_avail  out  1  an unread complete frame exists
rd_busy  out  1  read sweep in progress
frame_done  out  1  one-cycle pulse when a write frame completes
drop_cnt  out  16  frames overwritten unread (see optional feature)

Behaviour:
- Reset values: waddr=0, wdata=0, w_occur=0, w_buffer_id=001, raddr=0, r_buffer_id=000, r_occur=0, frame_avail=0, rd_busy=0, frame_done=0, drop_cnt=0. Internal wcnt=0, latest=000, latest_valid=0.
- Write side:
  - A sample is accepted when arm & s_valid.
  - One cycle after acceptance: w_occur=1, waddr=wcnt, wdata=s_data, w_buffer_id=current write buffer. Latency is 1.
  - wcnt increments per accepted sample.
  - When arm=0: w_occur=0 and wcnt clears to 0. The write buffer is unchanged and the partial data is ignored.
- Frame completion: occurs on an accepted sample with wcnt==MAX_TAP-1. On the same edge that registers that write:
  - wcnt->0 and frame_done pulses 1.
  - latest<=write buffer and latest_valid<=1.
  - If latest_valid was already 1 and no rd_start claims it this cycle, drop_cnt increments.
  - The new write buffer is the lowest set bit of ~(next_latest | next_read) & 3'b111.
  - The write-strobe outputs registered on that edge carry the old buffer id. Subsequent writes use the new id.
- Read FSM, R_IDLE:
  - rd_start & latest_valid -> R_READ: read buffer<=latest, latest_valid<=0, raddr<=0, rd_busy<=1.
  - rd_start with no frame available is ignored.
- Read FSM, R_READ:
  - r_buffer_id=read buffer.
  - r_occur=rd_en, registered so it is aligned with raddr.
  - raddr increments per cycle with rd_en=1 and holds when rd_en=0.
  - After the strobe at raddr==MAX_TAP-1: return to R_IDLE, r_buffer_id=000, r_occur=0, rd_busy=0, raddr=0.
  - rd_start during R_READ is ignored.
- Simultaneous frame completion and rd_start:
  - The reader takes the old latest.
  - The completing buffer becomes the new latest.
  - The writer moves to the third buffer.
  - No drop is counted.
- Invariant: write, latest (if valid) and read (if active) buffers are pairwise distinct. w_buffer_id and non-idle r_buffer_id are always exactly one-hot.
- frame_avail=latest_valid, registered.
- rst_n assertion mid-frame or mid-read returns all state to reset values asynchronously. The reader sees r_occur drop immediately.
- drop_cnt saturates at 16'hFFFF.

Optional Feature:
- TB_DROP_CNT_EN defined: drop_cnt counts overwritten unread frames as described above.
- Not defined: drop_cnt is constant 0 and its counter logic is not synthesized. All other behaviour is unchanged.

Test Plan:
- Reset then arm=1 with 616 consecutive s_valid carrying data=index -> w_occur on 616 cycles, waddr 0..615, w_buffer_id=001, one frame_done pulse after the 616th write, frame_avail=1, next w_buffer_id=010.
- After one frame, rd_start with rd_en=1 continuous -> r_buffer_id=001, r_occur for 616 cycles with raddr 0..615, then r_buffer_id=000, rd_busy=0, frame_avail=0.
- Reader holds buffer 001 with rd_en toggling; writer completes two frames -> writes alternate 010/100 and never touch 001; drop_cnt=1 (0 without TB_DROP_CNT_EN).
- rd_start on the exact cycle of frame completion, with latest=010 and write=100 -> read=010, latest=100, write=001, drop_cnt unchanged.
- arm dropped at wcnt=300 then re-raised -> the next write has waddr=0 with the same w_buffer_id, and no frame_done occurs until 616 fresh samples.
- rst_n pulsed low at raddr=200 -> r_occur=0 and r_buffer_id=000 asynchronously, and all outputs hold reset values.

Source files
------------

// File: rtl/tb_frame_ctrl_if.sv
// Capture-side and read-side signal bundle for the triple frame buffer controller.
// master = sample source / reader, slave = controller.
interface tb_frame_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              arm;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [2:0]        w_buffer_id;
  logic              w_occur;
  logic              rd_start;
  logic              rd_en;
  logic [ADDR_W-1:0] raddr;
  logic [2:0]        r_buffer_id;
  logic              r_occur;
  logic              frame_avail;
  logic              rd_busy;
  logic              frame_done;
  logic [15:0]       drop_cnt;

  modport master (
    output arm, s_valid, s_data, rd_start, rd_en,
    input  waddr, wdata, w_buffer_id, w_occur, raddr, r_buffer_id, r_occur,
           frame_avail, rd_busy, frame_done, drop_cnt
  );

  modport slave (
    input  arm, s_valid, s_data, rd_start, rd_en,
    output waddr, wdata, w_buffer_id, w_occur, raddr, r_buffer_id, r_occur,
           frame_avail, rd_busy, frame_done, drop_cnt
  );
endinterface

// File: rtl/tb_frame_ctrl.sv
// Triple frame buffer controller: write strobes 1 cycle after each accepted sample, writer never stalls,
// reader sweeps the latest complete frame under rd_en. TB_DROP_CNT_EN enables the overwritten-frame counter.
module tb_frame_ctrl #(
  parameter int MAX_TAP = 616,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  tb_frame_ctrl_if.slave bus
);

  typedef enum logic {R_IDLE, R_READ} rstate_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAX_TAP - 1);

  rstate_t           rstate_q, rstate_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        wid_q, wid_d;
  logic              w_occur_q, w_occur_d;
  logic [2:0]        wbuf_q, wbuf_d;
  logic [2:0]        latest_q, latest_d;
  logic              latest_valid_q, latest_valid_d;
  logic [2:0]        rbuf_q, rbuf_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              r_occur_q, r_occur_d;
  logic              rd_busy_q, rd_busy_d;
  logic              frame_avail_q, frame_avail_d;
  logic              frame_done_q, frame_done_d;

  logic       accept, fin, rd_claim, rd_end;
  logic [2:0] free_bufs;

  always_comb begin
    accept   = bus.arm & bus.s_valid;
    fin      = accept & (wcnt_q == LAST);
    rd_claim = (rstate_q == R_IDLE) & bus.rd_start & latest_valid_q;
    rd_end   = (rstate_q == R_READ) & r_occur_q & (raddr_q == LAST);

    rstate_d       = rstate_q;
    wcnt_d         = wcnt_q;
    waddr_d        = waddr_q;
    wdata_d        = wdata_q;
    wid_d          = wid_q;
    w_occur_d      = accept;
    wbuf_d         = wbuf_q;
    latest_d       = latest_q;
    latest_valid_d = latest_valid_q;
    rbuf_d         = rbuf_q;
    raddr_d        = raddr_q;
    r_occur_d      = 1'b0;
    rd_busy_d      = rd_busy_q;
    frame_done_d   = fin;
    free_bufs      = 3'b000;

    // Dropping arm abandons the partial frame but keeps the same buffer.
    if (!bus.arm) begin
      wcnt_d = '0;
    end else if (accept) begin
      wcnt_d = fin ? '0 : wcnt_q + 1'b1;
    end

    if (accept) begin
      waddr_d = wcnt_q;
      wdata_d = bus.s_data;
      wid_d   = wbuf_q;
    end

    // r_occur is registered from rd_en; raddr advances once the presented strobe is consumed.
    unique case (rstate_q)
      R_IDLE: begin
        if (rd_claim) begin
          rstate_d  = R_READ;
          rbuf_d    = latest_q;
          raddr_d   = '0;
          rd_busy_d = 1'b1;
        end
      end
      R_READ: begin
        if (rd_end) begin
          rstate_d  = R_IDLE;
          rbuf_d    = 3'b000;
          raddr_d   = '0;
          rd_busy_d = 1'b0;
        end else begin
          r_occur_d = bus.rd_en;
          if (r_occur_q) raddr_d = raddr_q + 1'b1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase

    if (fin) begin
      latest_d       = wbuf_q;
      latest_valid_d = 1'b1;
    end else if (rd_claim) begin
      latest_valid_d = 1'b0;
    end

    // New write buffer is the lowest one held by neither the new latest nor the reader.
    if (fin) begin
      free_bufs = ~(latest_d | rbuf_d);
      wbuf_d    = free_bufs & (~free_bufs + 3'd1);
    end

    frame_avail_d = latest_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q       <= R_IDLE;
      wcnt_q         <= '0;
      waddr_q        <= '0;
      wdata_q        <= '0;
      wid_q          <= 3'b001;
      w_occur_q      <= 1'b0;
      wbuf_q         <= 3'b001;
      latest_q       <= 3'b000;
      latest_valid_q <= 1'b0;
      rbuf_q         <= 3'b000;
      raddr_q        <= '0;
      r_occur_q      <= 1'b0;
      rd_busy_q      <= 1'b0;
      frame_avail_q  <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      rstate_q       <= rstate_d;
      wcnt_q         <= wcnt_d;
      waddr_q        <= waddr_d;
      wdata_q        <= wdata_d;
      wid_q          <= wid_d;
      w_occur_q      <= w_occur_d;
      wbuf_q         <= wbuf_d;
      latest_q       <= latest_d;
      latest_valid_q <= latest_valid_d;
      rbuf_q         <= rbuf_d;
      raddr_q        <= raddr_d;
      r_occur_q      <= r_occur_d;
      rd_busy_q      <= rd_busy_d;
      frame_avail_q  <= frame_avail_d;
      frame_done_q   <= frame_done_d;
    end
  end

`ifdef TB_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (fin && latest_valid_q && !rd_claim && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign bus.drop_cnt = drop_q;
`else
  assign bus.drop_cnt = 16'd0;
`endif

  assign bus.waddr       = waddr_q;
  assign bus.wdata       = wdata_q;
  assign bus.w_buffer_id = wid_q;
  assign bus.w_occur     = w_occur_q;
  assign bus.raddr       = raddr_q;
  assign bus.r_buffer_id = rbuf_q;
  assign bus.r_occur     = r_occur_q;
  assign bus.frame_avail = frame_avail_q;
  assign bus.rd_busy     = rd_busy_q;
  assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_tb_frame_ctrl.sv
// Randomized scoreboard bench for tb_frame_ctrl against a buffer-ownership reference model.
module tb_tb_frame_ctrl;
  localparam int MAX_TAP = 616;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tb_frame_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  tb_frame_ctrl #(.MAX_TAP(MAX_TAP), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
    logic [2:0]  b;
  } wexp_t;

  typedef struct packed {
    logic [9:0] a;
    logic [2:0] b;
  } rexp_t;

  typedef struct packed {
    logic        w_occur;
    logic        r_occur;
    logic        avail;
    logic        busy;
    logic [2:0]  rbuf;
    logic        done;
    logic [15:0] drop;
  } eexp_t;

  wexp_t wq[$];
  rexp_t rq[$];
  eexp_t eq[$];

  int checks = 0;
  int errors = 0;

  // Reference model: buffer ownership as indices 0..2, -1 meaning none.
  int m_wcnt, m_w, m_lat, m_rd, m_issued, m_drop;
  bit m_reading;
  int sim_hits;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wcnt = 0; m_w = 0; m_lat = -1; m_rd = -1;
    m_issued = 0; m_drop = 0; m_reading = 0;
  endtask

  task automatic step(input logic a, input logic sv, input logic rs, input logic re);
    logic [31:0] d;
    bit acc, fin, was_rd, ending, strobe, claim;
    wexp_t we;
    rexp_t re_e;
    eexp_t ee;
    @(negedge clk);
    d = $urandom;
    bus.arm = a; bus.s_valid = sv; bus.s_data = d; bus.rd_start = rs; bus.rd_en = re;

    acc    = a && sv;
    fin    = acc && (m_wcnt == MAX_TAP - 1);
    was_rd = m_reading;
    ending = was_rd && (m_issued == MAX_TAP);
    strobe = was_rd && !ending && re;
    claim  = !was_rd && rs && (m_lat >= 0);

    if (acc) begin
      we.a = 10'(m_wcnt); we.d = d; we.b = 3'(1 << m_w);
      wq.push_back(we);
    end
    if (ending) begin
      m_reading = 0; m_rd = -1;
    end
    if (strobe) begin
      re_e.a = 10'(m_issued); re_e.b = 3'(1 << m_rd);
      rq.push_back(re_e);
      m_issued++;
    end
    if (claim) begin
      m_rd = m_lat; m_reading = 1; m_issued = 0;
    end
    if (fin) begin
      if (m_lat >= 0 && !claim && m_drop < 65535) m_drop++;
      if (claim) sim_hits++;
      m_lat = m_w;
      for (int i = 0; i < 3; i++) begin
        if (i != m_lat && i != m_rd) begin
          m_w = i;
          break;
        end
      end
    end else if (claim) begin
      m_lat = -1;
    end
    if (!a) m_wcnt = 0;
    else if (acc) m_wcnt = fin ? 0 : m_wcnt + 1;

    ee.w_occur = acc;
    ee.r_occur = strobe;
    ee.avail   = (m_lat >= 0);
    ee.busy    = m_reading;
    ee.rbuf    = m_reading ? 3'(1 << m_rd) : 3'b000;
    ee.done    = fin;
`ifdef TB_DROP_CNT_EN
    ee.drop    = 16'(m_drop);
`else
    ee.drop    = 16'd0;
`endif
    eq.push_back(ee);
  endtask

  // Monitor: one per-edge expectation plus payload queues popped on each strobe.
  always @(posedge clk) begin
    eexp_t e;
    wexp_t w;
    rexp_t r;
    #1;
    if (rst_n) begin
      if (eq.size() > 0) begin
        e = eq.pop_front();
        chk("w_occur", 32'(bus.w_occur), 32'(e.w_occur));
        chk("r_occur", 32'(bus.r_occur), 32'(e.r_occur));
        chk("frame_avail", 32'(bus.frame_avail), 32'(e.avail));
        chk("rd_busy", 32'(bus.rd_busy), 32'(e.busy));
        chk("r_buffer_id", 32'(bus.r_buffer_id), 32'(e.rbuf));
        chk("frame_done", 32'(bus.frame_done), 32'(e.done));
        chk("drop_cnt", 32'(bus.drop_cnt), 32'(e.drop));
        chk("w_buffer_id_onehot", 32'($onehot(bus.w_buffer_id)), 32'd1);
      end
      if (bus.w_occur) begin
        if (wq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          w = wq.pop_front();
          chk("waddr", 32'(bus.waddr), 32'(w.a));
          chk("wdata", bus.wdata, w.d);
          chk("w_buffer_id", 32'(bus.w_buffer_id), 32'(w.b));
        end
      end
      if (bus.r_occur) begin
        if (rq.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
        else begin
          r = rq.pop_front();
          chk("raddr", 32'(bus.raddr), 32'(r.a));
          chk("r_buffer_id_strobe", 32'(bus.r_buffer_id), 32'(r.b));
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_waddr"}, 32'(bus.waddr), 32'd0);
    chk({tag, "_wdata"}, bus.wdata, 32'd0);
    chk({tag, "_w_occur"}, 32'(bus.w_occur), 32'd0);
    chk({tag, "_w_buffer_id"}, 32'(bus.w_buffer_id), 32'd1);
    chk({tag, "_raddr"}, 32'(bus.raddr), 32'd0);
    chk({tag, "_r_buffer_id"}, 32'(bus.r_buffer_id), 32'd0);
    chk({tag, "_r_occur"}, 32'(bus.r_occur), 32'd0);
    chk({tag, "_frame_avail"}, 32'(bus.frame_avail), 32'd0);
    chk({tag, "_rd_busy"}, 32'(bus.rd_busy), 32'd0);
    chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
    chk({tag, "_drop_cnt"}, 32'(bus.drop_cnt), 32'd0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (m_reading && n < 3000) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    if (m_reading) chk({tag, "_drain_timeout"}, 32'd1, 32'd0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk({tag, "_wq_empty"}, 32'(wq.size()), 32'd0);
    chk({tag, "_rq_empty"}, 32'(rq.size()), 32'd0);
  endtask

  initial begin
    logic a, sv, rs, re;
    bit hit;
    bus.arm = 0; bus.s_valid = 0; bus.s_data = '0; bus.rd_start = 0; bus.rd_en = 0;
    model_reset();
    sim_hits = 0;
    repeat (3) @(posedge clk);
    #2;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Partial frame abandoned at 300, then a full frame into buffer 001.
    repeat (300) step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (MAX_TAP) step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (MAX_TAP + 4) step(1'b1, 1'b0, 1'b0, 1'b1);

    // Random traffic; rd_start is steered onto frame-completion cycles half the time.
    for (int k = 0; k < 9000; k++) begin
      a  = ($urandom_range(0, 499) != 0);
      sv = ($urandom_range(0, 9) != 0);
      re = ($urandom_range(0, 9) < 7);
      rs = ($urandom_range(0, 39) == 0);
      if (a && sv && m_wcnt == MAX_TAP - 1 && !m_reading && m_lat >= 0)
        rs = 1'($urandom_range(0, 1));
      step(a, sv, rs, re);
    end
    drain("random");

    // Asynchronous reset in the middle of a read sweep.
    hit = 0;
    for (int k = 0; k < 4000 && !hit; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
      @(posedge clk); #2;
      if (bus.r_occur && bus.raddr == 10'd200) hit = 1;
    end
    if (!hit) chk("reach_raddr_200", 32'd0, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_r_occur", 32'(bus.r_occur), 32'd0);
    chk("async_r_buffer_id", 32'(bus.r_buffer_id), 32'd0);
    chk_reset_vals("async");
    wq.delete(); rq.delete(); eq.delete();
    model_reset();
    bus.arm = 0; bus.s_valid = 0; bus.rd_start = 0; bus.rd_en = 0;
    @(posedge clk); #2;
    chk_reset_vals("held");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) step(1'b1, 1'b1, 1'b0, 1'b0);
    drain("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
